// File: rtl/viterbi_ctrl_pkg.sv
// Shared definitions for the Viterbi decoder front-end controller.
package viterbi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_TB    = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // BMU stage codes: the first two trellis steps start from the known zero state
  localparam logic [1:0] STG_FIRST  = 2'd0;
  localparam logic [1:0] STG_SECOND = 2'd1;
  localparam logic [1:0] STG_BMU    = 2'd2;

  localparam logic [1:0] TAIL_PAIR  = 2'b00;

  localparam int DEF_MAX_LEN  = 32;
  localparam int DEF_TAIL_LEN = 2;
  localparam int DEF_PIPE_LAT = 3;

endpackage

// File: rtl/viterbi_stage_sel.sv
// Maps the issued-pair count to the BMU stage code.
module viterbi_stage_sel
  import viterbi_ctrl_pkg::*;
#(
  parameter int CW = 6
) (
  input  logic [CW-1:0] sym_cnt_i,
  output logic [1:0]    stage_o
);

  // first two pairs use the reduced start-up stages, everything after is steady state
  always_comb begin
    if (sym_cnt_i == '0)           stage_o = STG_FIRST;
    else if (sym_cnt_i == CW'(1))  stage_o = STG_SECOND;
    else                           stage_o = STG_BMU;
  end

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame controller: feeds received pairs and zero tail to the BMU chain,
// waits for the path metrics to settle, then hands off to traceback.
module viterbi_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int TAIL_LEN = DEF_TAIL_LEN,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  input  logic [1:0]                              in_pair,
  input  logic                                    in_last,
  output logic                                    in_ready,
  output logic [1:0]                              bmu_pair,
  output logic [1:0]                              bmu_stage,
  output logic                                    bmu_valid,
  output logic                                    tb_start,
  output logic [$clog2(MAX_LEN+TAIL_LEN+1)-1:0]   tb_len,
  input  logic                                    tb_done,
  output logic                                    frame_done,
  output logic                                    overrun
);

  localparam int CW = $clog2(MAX_LEN+TAIL_LEN+1);
  localparam int TW = (TAIL_LEN > 0) ? $clog2(TAIL_LEN+1) : 1;
  localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT+1) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] sym_cnt_q, sym_cnt_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [CW-1:0] tb_len_q, tb_len_d;
  logic [1:0]    pair_q, pair_d;
  logic [1:0]    stage_q, stage_d;
  logic          valid_q, valid_d;
  logic          tb_start_q, tb_start_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic [1:0]    stage_w;
  logic          accept;
  logic [CW-1:0] sym_cnt_inc;

  viterbi_stage_sel #(.CW(CW)) u_stage_sel (
    .sym_cnt_i (sym_cnt_q),
    .stage_o   (stage_w)
  );

  assign in_ready    = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign accept      = in_valid && in_ready;
  // saturating so a malformed frame can never wrap the depth count
  assign sym_cnt_inc = (sym_cnt_q == CW'(MAX_LEN+TAIL_LEN)) ? sym_cnt_q : sym_cnt_q + CW'(1);

  // next-state and output-register decode
  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    tail_cnt_d   = tail_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    tb_len_d     = tb_len_q;
    pair_d       = pair_q;
    stage_d      = stage_q;
    valid_d      = 1'b0;
    tb_start_d   = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (accept) begin
          valid_d   = 1'b1;
          pair_d    = in_pair;
          stage_d   = stage_w;
          sym_cnt_d = sym_cnt_inc;
          state_d   = ST_RUN;
          if (in_last) begin
            state_d    = ST_FLUSH;
            tail_cnt_d = '0;
          end else if (sym_cnt_q == CW'(MAX_LEN-1)) begin
            // frame hit the length cap: truncate and flag it
            state_d    = ST_FLUSH;
            tail_cnt_d = '0;
            overrun_d  = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        valid_d    = 1'b1;
        pair_d     = TAIL_PAIR;
        stage_d    = stage_w;
        sym_cnt_d  = sym_cnt_inc;
        tail_cnt_d = tail_cnt_q + TW'(1);
        if (tail_cnt_q == TW'(TAIL_LEN-1)) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // first DRAIN cycle still shows the last tail pair, hence count to PIPE_LAT inclusive
        if (drain_cnt_q == DW'(PIPE_LAT)) begin
          tb_len_d   = sym_cnt_q;
          tb_start_d = 1'b1;
          state_d    = ST_TB;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      ST_TB: begin
        // tb_done is not trusted in the cycle the start pulse is still out
        if (tb_done && !tb_start_q) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        sym_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, counters and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sym_cnt_q    <= '0;
      tail_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      tb_len_q     <= '0;
      pair_q       <= '0;
      stage_q      <= '0;
      valid_q      <= 1'b0;
      tb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      tail_cnt_q   <= tail_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      tb_len_q     <= tb_len_d;
      pair_q       <= pair_d;
      stage_q      <= stage_d;
      valid_q      <= valid_d;
      tb_start_q   <= tb_start_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bmu_pair   = pair_q;
  assign bmu_stage  = stage_q;
  assign bmu_valid  = valid_q;
  assign tb_start   = tb_start_q;
  assign tb_len     = tb_len_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Scoreboard bench for viterbi_ctrl: driver pushes expected BMU issues and
// traceback depths, monitor pops and compares as the DUT presents them.
module tb_viterbi_ctrl;

  localparam int MAX_LEN  = 32;
  localparam int TAIL_LEN = 2;
  localparam int PIPE_LAT = 3;
  localparam int LW       = $clog2(MAX_LEN+TAIL_LEN+1);

  typedef struct {
    logic [1:0] pair;
    logic [1:0] stage;
    logic       ovr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_pair = 2'b00;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [1:0]    bmu_pair;
  logic [1:0]    bmu_stage;
  logic          bmu_valid;
  logic          tb_start;
  logic [LW-1:0] tb_len;
  logic          tb_done = 1'b0;
  logic          frame_done;
  logic          overrun;

  int chk = 0;
  int fails = 0;
  int k = 0;
  int cyc = 0;
  int last_bv = 0;
  int ts = 0;
  int fd_exp = -1;
  int resp_d = 1;
  bit hold_done = 0;
  bit in_tb = 0;
  bit fd_next = 0;
  int frames_exp = 0;
  int frames_seen = 0;
  int cur_tblen = 0;
  exp_t exp_q[$];
  int   tblen_q[$];

  viterbi_ctrl #(.MAX_LEN(MAX_LEN), .TAIL_LEN(TAIL_LEN), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pair(in_pair), .in_last(in_last),
    .in_ready(in_ready), .bmu_pair(bmu_pair), .bmu_stage(bmu_stage), .bmu_valid(bmu_valid),
    .tb_start(tb_start), .tb_len(tb_len), .tb_done(tb_done), .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_stage(input int n);
    return (n == 0) ? 2'd0 : (n == 1) ? 2'd1 : 2'd2;
  endfunction

  task automatic push(input logic [1:0] p, input logic ovr);
    exp_t e;
    e.pair = p; e.stage = exp_stage(k); e.ovr = ovr;
    exp_q.push_back(e);
    k++;
  endtask

  // offer one symbol and wait for it to be taken
  task automatic send(input logic [1:0] p, input logic last, input logic ovr);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_pair = p; in_last = last;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("send_timeout", 0, 1);
    push(p, ovr);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic frame(input logic [1:0] syms[$], input bit use_last, input int gap);
    int n;
    int w;
    k = 0;
    n = (!use_last && syms.size() > MAX_LEN) ? MAX_LEN : syms.size();
    for (int i = 0; i < n; i++) begin
      send(syms[i], use_last && (i == n-1), !use_last && (i == MAX_LEN-1));
      if (gap > 0 && i < n-1)
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (g > 0) check("gap_no_valid", bmu_valid, 0);
        end
    end
    for (int t = 0; t < TAIL_LEN; t++) push(2'b00, 1'b0);
    tblen_q.push_back(k);
    frames_exp++;
    if (!use_last) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        in_valid = 1'b1; in_pair = 2'b11;
        #1 check("ready_low_after_overrun", in_ready, 0);
      end
      in_valid = 1'b0;
    end
    w = 0;
    while (frames_seen < frames_exp && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("frame_complete", frames_seen, frames_exp);
    repeat (2) @(negedge clk);
  endtask

  // monitor: pops expectations whenever the DUT presents something, and plays traceback
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (fd_next) begin
          check("ready_after_done", in_ready, 1);
          fd_next = 0;
        end
        if (bmu_valid) begin
          if (exp_q.size() == 0) check("bmu_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("bmu_pair", bmu_pair, e.pair);
            check("bmu_stage", bmu_stage, e.stage);
            check("overrun", overrun, e.ovr);
          end
          last_bv = cyc;
        end else if (overrun) check("overrun_stray", 1, 0);
        if (tb_start) begin
          check("drain_cycles", cyc - last_bv - 1, PIPE_LAT);
          if (tblen_q.size() == 0) check("tb_start_unexpected", 1, 0);
          else begin
            cur_tblen = tblen_q.pop_front();
            check("tb_len", tb_len, cur_tblen);
          end
          ts = cyc; in_tb = 1;
          fd_exp = ts + ((resp_d < 1) ? 1 : resp_d) + 1;
        end else if (in_tb && !frame_done) check("tb_len_stable", tb_len, cur_tblen);
        if (frame_done) begin
          check("frame_done_cycle", cyc, fd_exp);
          check("ready_low_in_done", in_ready, 0);
          frames_seen++;
          in_tb = 0; fd_exp = -1; fd_next = 1;
        end
        tb_done = hold_done || (in_tb && resp_d >= 1 && cyc == ts + resp_d);
      end else begin
        tb_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] q[$];
    repeat (3) @(negedge clk);
    check("rst_bmu_valid", bmu_valid, 0);
    check("rst_bmu_pair", bmu_pair, 0);
    check("rst_bmu_stage", bmu_stage, 0);
    check("rst_tb_start", tb_start, 0);
    check("rst_tb_len", tb_len, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    #1 check("ready_after_rst", in_ready, 1);

    // basic frame, tb_len 4+2
    resp_d = 2;
    q = '{2'b11, 2'b01, 2'b10, 2'b00};
    frame(q, 1, 0);

    // single symbol: tail stages 1,2, tb_len 3
    resp_d = 1;
    q = '{2'b11};
    frame(q, 1, 0);

    // stalls mid-frame
    resp_d = 3;
    q = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    frame(q, 1, 2);

    // 33 offered without last: truncated at 32, tb_len 34
    resp_d = 1;
    q.delete();
    for (int i = 0; i < 33; i++) q.push_back(2'(i % 4));
    frame(q, 0, 0);

    // tb_done stuck high: must not complete early
    hold_done = 1; resp_d = 0;
    q = '{2'b10, 2'b01, 2'b11};
    frame(q, 1, 0);
    hold_done = 0; resp_d = 1;

    // reset during FLUSH abandons the frame
    k = 0;
    send(2'b11, 1'b0, 1'b0);
    send(2'b01, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_bmu_valid", bmu_valid, 0);
    check("midrst_bmu_pair", bmu_pair, 0);
    check("midrst_bmu_stage", bmu_stage, 0);
    check("midrst_tb_len", tb_len, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_frame_done", frame_done, 0);
    exp_q.delete(); tblen_q.delete();
    in_tb = 0; fd_exp = -1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("ready_after_midrst", in_ready, 1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      #1 check("no_done_after_abandon", frame_done, 0);
    end

    q = '{2'b01, 2'b10};
    frame(q, 1, 0);

    check("exp_queue_empty", exp_q.size(), 0);
    check("tblen_queue_empty", tblen_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule
